// File: rtl/wb_cmd_initiator.sv
// Byte-stream command parser driving a single-outstanding Wishbone B4 pipelined initiator.
// Optional feature: define WB_CMD_TIMEOUT_EN for the ack-wait timeout and sticky error_o.
module wb_cmd_initiator #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_i,
    input  logic [7:0]            cmd_data_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    output logic [7:0]            rsp_data_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [7:0]            wb_data_o,
    input  logic [7:0]            wb_data_i,
    output logic                  wb_we_o,
    output logic                  wb_cycle_o,
    output logic                  wb_strobe_o,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i,
    output logic                  busy_o,
    output logic                  error_o,
    output logic [2:0]            dbg_state
);

    // Both byte streams: a byte moves on a rising edge where valid and ready are both high;
    // the producer holds data stable while valid is high and ready is low.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        WR_DATA = 3'd3,
        WB_REQ  = 3'd4,
        WB_WAIT = 3'd5,
        RSP     = 3'd6
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  op_write;
    logic [3:0]            count;
    logic [7:0]            addr_hi;
    logic [15:0]           addr_full;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wdata;
    logic [7:0]            rdata;
    logic                  cmd_fire;
    logic                  in_bus;
    logic                  last;
    logic                  xfer_done;
    logic                  timed_out;
    logic                  timeout_hit;
    logic                  advance;

    assign cmd_ready_o = !wb_reset_i &&
                         (state == IDLE || state == ADDR_HI || state == ADDR_LO || state == WR_DATA);
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign in_bus      = (state == WB_REQ) || (state == WB_WAIT);
    assign last        = (count == 4'd0);
    assign addr_full   = {addr_hi, cmd_data_i};
    assign advance     = (xfer_done && op_write) || (state == RSP && rsp_ready_i);

    assign wb_cycle_o  = in_bus;
    assign wb_strobe_o = (state == WB_REQ);
    assign wb_we_o     = op_write;
    assign wb_addr_o   = addr;
    assign wb_data_o   = wdata;
    assign rsp_valid_o = (state == RSP);
    assign rsp_data_o  = rdata;
    assign busy_o      = (state != IDLE);
    assign dbg_state   = state;

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An ack with strobe accepted in the same cycle finishes the transfer without WB_WAIT.
    always_comb begin
        state_next = state;
        xfer_done  = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE:    if (cmd_fire) state_next = ADDR_HI;
            ADDR_HI: if (cmd_fire) state_next = ADDR_LO;
            ADDR_LO: if (cmd_fire) state_next = op_write ? WR_DATA : WB_REQ;
            WR_DATA: if (cmd_fire) state_next = WB_REQ;
            WB_REQ: begin
                if (!wb_stall_i) begin
                    if (wb_ack_i) xfer_done = 1'b1;
                    else          state_next = WB_WAIT;
                end
            end
            WB_WAIT: if (wb_ack_i) xfer_done = 1'b1;
            RSP:     if (rsp_ready_i) state_next = last ? IDLE : WB_REQ;
            default: state_next = IDLE;
        endcase
        if (timeout_hit && !xfer_done) begin
            timed_out = 1'b1;
            xfer_done = 1'b1;
        end
        if (xfer_done) begin
            if (!op_write) state_next = RSP;
            else           state_next = last ? IDLE : WR_DATA;
        end
    end

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            op_write <= 1'b0;
            count    <= 4'd0;
            addr_hi  <= 8'd0;
            addr     <= '0;
            wdata    <= 8'd0;
            rdata    <= 8'd0;
        end else begin
            if (cmd_fire) begin
                case (state)
                    IDLE: begin
                        op_write <= cmd_data_i[7];
                        count    <= cmd_data_i[3:0];
                    end
                    ADDR_HI: addr_hi <= cmd_data_i;
                    ADDR_LO: addr    <= addr_full[ADDR_WIDTH-1:0];
                    WR_DATA: wdata   <= cmd_data_i;
                    default: ;
                endcase
            end
            if (xfer_done && !op_write) begin
                rdata <= timed_out ? 8'hFF : wb_data_i;
            end
            // count is remaining-minus-one; it only wraps on the final transfer, where it is unused.
            if (advance) begin
                addr  <= addr + ADDR_WIDTH'(1);
                count <= count - 4'd1;
            end
        end
    end

`ifdef WB_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          error_q;

    // timer holds the number of bus cycles already spent on the current transfer.
    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            timer   <= '0;
            error_q <= 1'b0;
        end else begin
            timer <= (in_bus && !xfer_done) ? timer + TW'(1) : '0;
            if (timed_out) begin
                error_q <= 1'b1;
            end else if (state == IDLE && cmd_fire) begin
                error_q <= 1'b0;
            end
        end
    end

    assign timeout_hit = in_bus && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign error_o     = error_q;
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
    assign error_o               = 1'b0;
`endif

endmodule

// File: doc/wb_cmd_initiator.md
WB_CMD_INITIATOR -- requirements
Module: wb_cmd_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, Wishbone address width (1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, ack-wait limit in clocks (used only with WB_CMD_TIMEOUT_EN).
REQ-003 SHALL have ports: wb_clock_i in 1 sole clock; wb_reset_i in 1 asynchronous, active-high reset.
REQ-004 SHALL have command stream ports: cmd_data_i in 8 command byte; cmd_valid_i in 1 byte present; cmd_ready_o out 1 byte accepted when both high.
REQ-005 SHALL have response stream ports: rsp_data_o out 8 read byte; rsp_valid_o out 1 byte present; rsp_ready_i in 1 consumer accepts.
REQ-006 SHALL have Wishbone B4 pipelined initiator ports: wb_addr_o out ADDR_WIDTH; wb_data_o out 8; wb_data_i in 8; wb_we_o out 1; wb_cycle_o out 1; wb_strobe_o out 1; wb_stall_i in 1; wb_ack_i in 1.
REQ-007 SHALL have status ports: busy_o out 1 command in progress; error_o out 1 sticky timeout flag.

Function
REQ-008 SHALL parse commands as: opcode byte (bit7=1 write, 0 read; bits[3:0]=count-1, giving 1..16 transfers; bits[6:4] ignored), address high byte, address low byte, then count data bytes for writes only.
REQ-009 SHALL form the start address from {hi,lo}, truncated to ADDR_WIDTH LSBs.
REQ-010 SHALL implement states IDLE, ADDR_HI, ADDR_LO, WR_DATA, WB_REQ, WB_WAIT, RSP.
REQ-011 SHALL drive cmd_ready_o high only in IDLE, ADDR_HI, ADDR_LO and WR_DATA.
REQ-012 SHALL transition: IDLE->ADDR_HI on accepted opcode; ADDR_HI->ADDR_LO on accepted byte; ADDR_LO->WR_DATA (write) or WB_REQ (read); WR_DATA->WB_REQ on accepted byte.
REQ-013 SHALL, in WB_REQ, assert wb_cycle_o and wb_strobe_o, holding strobe, address, data and we stable while wb_stall_i is high, and move to WB_WAIT in the cycle strobe is sampled with wb_stall_i low.
REQ-014 SHALL keep wb_cycle_o high and wb_strobe_o low in WB_WAIT until wb_ack_i, then deassert wb_cycle_o, with at most one transfer outstanding.
REQ-015 SHALL accept wb_ack_i in the same cycle strobe is accepted, skipping WB_WAIT.
REQ-016 SHALL, on read ack, register wb_data_i into rsp_data_o and enter RSP with rsp_valid_o high the next cycle, holding it until rsp_ready_i is high.
REQ-017 SHALL, on write ack or response handshake, increment the address modulo 2^ADDR_WIDTH (0xFFFF->0x0000 at default) and return to WR_DATA/WB_REQ if transfers remain, else IDLE.
REQ-018 SHALL assert strobe the cycle after the triggering byte is accepted (last address byte for reads, data byte for writes).
REQ-019 SHALL drive busy_o high in every state except IDLE.

Reset
REQ-020 SHALL, on wb_reset_i high, asynchronously enter IDLE and clear wb_cycle_o, wb_strobe_o, wb_we_o, rsp_valid_o, busy_o, error_o, wb_addr_o and wb_data_o to 0, aborting any transfer immediately.
REQ-021 SHALL hold cmd_ready_o low while wb_reset_i is high.

Configuration
REQ-022 SHALL, when WB_CMD_TIMEOUT_EN is defined, count cycles in WB_REQ/WB_WAIT and, on reaching TIMEOUT_CYCLES without ack, drop wb_cycle_o/wb_strobe_o, set error_o, and continue as if acked, with read data 8'hFF.
REQ-023 SHALL clear error_o when the next opcode is accepted.
REQ-024 SHALL, when WB_CMD_TIMEOUT_EN is undefined, wait indefinitely for ack, tie error_o to 0, and omit the counter.

Verification
REQ-025 Write 0x80,0x01,0x00,0xA5 to zero-wait-state target -> one WB write addr 0x0100 data 0xA5, wb_we_o=1, busy_o low afterward.
REQ-026 Read 0x03,0x00,0x10 with memory 0x10..0x13=11,22,33,44 -> four rsp bytes 0x11,0x22,0x33,0x44; strobe 1 cycle after addr-lo accept, rsp_valid_o 1 cycle after each ack.
REQ-027 Write count 2 at 0xFFFF, data 0x5A,0xC3 -> writes to 0xFFFF then 0x0000.
REQ-028 Read with wb_stall_i high 3 cycles and rsp_ready_i low 5 cycles -> strobe and address held stable under stall; rsp_data_o held stable and no new strobe until handshake.
REQ-029 Reset asserted during WB_WAIT -> wb_cycle_o low immediately; next opcode 0x00,0x00,0x20 processed normally.
REQ-030 With WB_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=8, and no-ack target, read 1 byte -> cycle dropped after 8 clocks, rsp 0xFF, error_o=1 until next opcode accepted.
